pipelined_rca_adder: RTL

//  Parametrised, pipelined ripple-carry add/subtract unit for the SimpleALU datapath. Generalises the 8-bit RCA:
//  - WIDTH-bit operands, split into CHUNK-bit ripple slices, one pipeline stage per slice.
//  - Per-transaction add/sub mode and a valid/ready handshake with backpressure.
//  - Sits between the ALU operand registers and the result writeback.

---
 rtl/pipelined_rca_adder_pkg.sv | 23 ++
 rtl/pipelined_rca_adder_rca_chunk.sv | 38 +++
 rtl/pipelined_rca_adder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pipelined_rca_adder_pkg.sv
// ---------------------------------------------------------------------------
// pipelined_rca_adder_pkg
//   Shared definitions for the pipelined ripple-carry add/subtract unit:
//   operation encodings for the 'sub' control bit, the stage-count
//   derivation and the WIDTH/CHUNK legality check.
// ---------------------------------------------------------------------------
package pipelined_rca_adder_pkg;

    // Encoding of the per-transaction mode bit.
    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;

    // Number of pipeline stages: one ripple slice of 'chunk' bits per stage.
    function automatic int stages_of(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A configuration is legal only when the width splits into whole slices.
    function automatic bit chunk_fits(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/pipelined_rca_adder_rca_chunk.sv
// ---------------------------------------------------------------------------
// rca_chunk
//   Purely combinational CHUNK-bit ripple-carry adder slice.
//   Ports:
//     a        in   CHUNK  operand A slice
//     b        in   CHUNK  operand B slice (already inverted for subtract)
//     cin      in   1      carry into bit 0 of the slice
//     s        out  CHUNK  sum slice
//     cout     out  1      carry out of the slice MSB
//     c_msb_in out  1      carry into the slice MSB (for signed overflow)
// ---------------------------------------------------------------------------
module rca_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    // carry[i] is the carry into bit i; carry[CHUNK] leaves the slice.
    logic [CHUNK:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
            assign s[gi]         = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout     = carry[CHUNK];
    assign c_msb_in = carry[CHUNK - 1];

endmodule

// File: rtl/pipelined_rca_adder.sv
// ---------------------------------------------------------------------------
// pipelined_rca_adder
//   Pipelined WIDTH-bit ripple-carry add/subtract unit. The operands are
//   resolved CHUNK bits per stage, STAGES = WIDTH/CHUNK stages, with a
//   valid/ready handshake and full-pipe backpressure. A transaction accepted
//   on clock edge N presents its result after edge N+STAGES.
//
//   Optional feature macro: OVERFLOW_FLAG_EN
//     defined   -> 'ovf' port present, signed overflow registered with sum
//     undefined -> 'ovf' port and its logic are absent
//
//   Ports:
//     clock      in   1      rising-edge clock
//     reset      in   1      asynchronous active-high reset
//     in_valid   in   1      operand transaction offered
//     in_ready   out  1      transaction accepted this cycle (combinational)
//     in0        in   WIDTH  operand A
//     in1        in   WIDTH  operand B
//     cin        in   1      carry in (add mode only)
//     sub        in   1      0: A+B+cin, 1: A+~B+1
//     out_valid  out  1      result available
//     out_ready  in   1      downstream consumes the result
//     sum        out  WIDTH  result (modulo 2^WIDTH)
//     out        out  1      carry out of the MSB (sub: 1 = no borrow)
//     ovf        out  1      signed overflow (OVERFLOW_FLAG_EN only)
// ---------------------------------------------------------------------------
module pipelined_rca_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             out
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic             ovf
`endif
);

    import pipelined_rca_adder_pkg::*;

    localparam int STAGES = stages_of(WIDTH, CHUNK);

    generate
        if (!chunk_fits(WIDTH, CHUNK)) begin : g_bad_cfg
            $error("pipelined_rca_adder: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    // Register bank k holds a transaction whose slices 0..k-1 are resolved.
    // Bank 0 is the input capture; bank STAGES is the output register.
    //   a_q/b_q : operands (b already inverted for subtract); the upper,
    //             still-unprocessed slices form the skew path
    //   s_q     : resolved low result slices (the deskew path)
    //   c_q     : carry into the next slice to be resolved
    logic             valid_q [0:STAGES];
    logic             c_q     [0:STAGES];
    logic [WIDTH-1:0] s_q     [0:STAGES];
    logic [WIDTH-1:0] a_q     [0:STAGES-1];
    logic [WIDTH-1:0] b_q     [0:STAGES-1];

    logic [WIDTH-1:0] s_d     [0:STAGES];

    logic [CHUNK-1:0] chunk_s    [0:STAGES-1];
    logic             chunk_cout [0:STAGES-1];
    logic             chunk_cmsb [0:STAGES-1];

    logic             advance;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

    // The pipe only stalls when a finished result is waiting to be taken.
    assign advance  = !valid_q[STAGES] || out_ready;
    assign in_ready = advance;

    // Subtract is A + ~B + 1: invert B on entry and force the first carry.
    assign b_in = (sub == ALU_OP_SUB) ? ~in1 : in1;
    assign c_in = (sub == ALU_OP_SUB) ? 1'b1 : cin;

    // One ripple slice per stage, each working on its own column of bank k.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            rca_chunk #(
                .CHUNK(CHUNK)
            ) u_chunk (
                .a        (a_q[gi][gi*CHUNK +: CHUNK]),
                .b        (b_q[gi][gi*CHUNK +: CHUNK]),
                .cin      (c_q[gi]),
                .s        (chunk_s[gi]),
                .cout     (chunk_cout[gi]),
                .c_msb_in (chunk_cmsb[gi])
            );
        end
    endgenerate

    // Merge each freshly resolved slice into the partial result it travels with.
    always_comb begin
        for (int k = 0; k <= STAGES; k++) begin
            s_d[k] = '0;
        end
        for (int k = 0; k < STAGES; k++) begin
            s_d[k + 1]                    = s_q[k];
            s_d[k + 1][k*CHUNK +: CHUNK]  = chunk_s[k];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= STAGES; k++) begin
                valid_q[k] <= 1'b0;
                c_q[k]     <= 1'b0;
                s_q[k]     <= '0;
            end
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else if (advance) begin
            // Stage 0 takes a bubble whenever nothing is offered.
            valid_q[0] <= in_valid;
            a_q[0]     <= in0;
            b_q[0]     <= b_in;
            c_q[0]     <= c_in;
            s_q[0]     <= '0;
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k + 1] <= valid_q[k];
                c_q[k + 1]     <= chunk_cout[k];
                s_q[k + 1]     <= s_d[k + 1];
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                a_q[k + 1] <= a_q[k];
                b_q[k + 1] <= b_q[k];
            end
        end
    end

    assign out_valid = valid_q[STAGES];
    assign sum       = s_q[STAGES];
    assign out       = c_q[STAGES];

`ifdef OVERFLOW_FLAG_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    logic ovf_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= chunk_cmsb[STAGES-1] ^ chunk_cout[STAGES-1];
        end
    end

    assign ovf = ovf_q;
`else
    // The MSB carry-in is only needed for the overflow flag.
    logic unused_cmsb;
    assign unused_cmsb = chunk_cmsb[STAGES-1];
`endif

endmodule
